// File: rtl/z80fi_rec_pkg.sv
// Shared types for the z80fi instruction recorder: M-cycle codes, FSM states, slot payload.
// Optional error reporting is enabled with the Z80FI_REC_ERR_EN macro.
package z80fi_rec_pkg;

  localparam int unsigned CYCLE_W          = 3;
  localparam int unsigned DEF_MAX_MCYCLES  = 4;
  localparam int unsigned DEF_MAX_INSN_LEN = 4;
  localparam int unsigned DEF_TCYC_W       = 4;

  typedef enum logic [CYCLE_W-1:0] {
    CYCLE_M1       = 3'd1,
    CYCLE_MEMRD    = 3'd2,
    CYCLE_MEMWR    = 3'd3,
    CYCLE_IORD     = 3'd4,
    CYCLE_IOWR     = 3'd5,
    CYCLE_EXTENDED = 3'd6,
    CYCLE_NONE     = 3'd7
  } cycle_e;

  typedef logic [1:0] rec_state_t;
  localparam rec_state_t ST_IDLE = 2'd0;
  localparam rec_state_t ST_REC  = 2'd1;
  localparam rec_state_t ST_RET  = 2'd2;

  typedef struct packed {
    logic [CYCLE_W-1:0]    mtype;
    logic [DEF_TCYC_W-1:0] tcycles;
  } slot_t;

endpackage

// File: rtl/z80fi_mcycle_slot.sv
// One recorded M-cycle slot: type plus saturating T-state counter.
// sat_c exists only when Z80FI_REC_ERR_EN is defined.
module z80fi_mcycle_slot
  import z80fi_rec_pkg::*;
#(
  parameter int unsigned TCYC_W = DEF_TCYC_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic               tick,
  input  logic [CYCLE_W-1:0] load_type,
  output logic [CYCLE_W-1:0] snap_type_c,
  output logic [TCYC_W-1:0]  snap_tcycles_c
`ifdef Z80FI_REC_ERR_EN
  ,
  output logic               sat_c
`endif
);

  localparam logic [TCYC_W-1:0] TCYC_MAX = '1;

  logic [CYCLE_W-1:0] mtype_q;
  logic [TCYC_W-1:0]  tcyc_q;
  logic [TCYC_W-1:0]  tcyc_ticked;

  // Snapshot reflects this clk's tick; a load only shows when it belongs to the same record.
  always_comb begin
    tcyc_ticked = tcyc_q;
    if (tick && (tcyc_q != TCYC_MAX)) tcyc_ticked = tcyc_q + TCYC_W'(1);
    snap_type_c    = mtype_q;
    snap_tcycles_c = tcyc_ticked;
    if (load && !clear) begin
      snap_type_c    = load_type;
      snap_tcycles_c = TCYC_W'(1);
    end
  end

`ifdef Z80FI_REC_ERR_EN
  assign sat_c = tick && (tcyc_q == TCYC_MAX);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mtype_q <= CYCLE_W'(CYCLE_NONE);
      tcyc_q  <= '0;
    end else if (load) begin
      mtype_q <= load_type;
      tcyc_q  <= TCYC_W'(1);
    end else if (clear) begin
      mtype_q <= CYCLE_W'(CYCLE_NONE);
      tcyc_q  <= '0;
    end else begin
      tcyc_q  <= tcyc_ticked;
    end
  end

endmodule

// File: rtl/z80fi_insn_recorder.sv
// Assembles one retirement record per instruction from core fetch/M-cycle events.
// Define Z80FI_REC_ERR_EN to add the z80fi_rec_err overflow/protocol flag.
module z80fi_insn_recorder
  import z80fi_rec_pkg::*;
#(
  parameter int unsigned MAX_MCYCLES  = DEF_MAX_MCYCLES,
  parameter int unsigned MAX_INSN_LEN = DEF_MAX_INSN_LEN,
  parameter int unsigned TCYC_W       = DEF_TCYC_W
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  insn_start,
  input  logic                                  insn_done,
  input  logic                                  mcycle_start,
  input  logic [CYCLE_W-1:0]                    mcycle_type,
  input  logic                                  fetch_strobe,
  input  logic [7:0]                            fetch_data,
  output logic                                  z80fi_valid,
  output logic [8*MAX_INSN_LEN-1:0]             z80fi_insn,
  output logic [$clog2(MAX_INSN_LEN+1)-1:0]     z80fi_insn_len,
  output logic [MAX_MCYCLES*CYCLE_W-1:0]        z80fi_mcycle_type,
  output logic [MAX_MCYCLES*TCYC_W-1:0]         z80fi_tcycles
`ifdef Z80FI_REC_ERR_EN
  ,
  output logic                                  z80fi_rec_err
`endif
);

  localparam int unsigned LEN_W = $clog2(MAX_INSN_LEN+1);
  localparam int unsigned IDX_W = $clog2(MAX_MCYCLES+1);

  rec_state_t state, state_nxt;

  logic [IDX_W-1:0] idx_q;
  logic             mc_ovf_q;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       byte_q [MAX_INSN_LEN];

  logic             rec, evt_ok, done_act;
  logic [IDX_W-1:0] base_idx;
  logic             base_ovf;
  logic [LEN_W-1:0] base_len;
  logic             mc_take, mc_drop, fb_take, fb_old, old_tick_en;

  logic [MAX_MCYCLES-1:0]             load_v, tick_v;
  logic [MAX_MCYCLES*CYCLE_W-1:0]     snap_types;
  logic [MAX_MCYCLES*TCYC_W-1:0]      snap_tcycles;
  logic [8*MAX_INSN_LEN-1:0]          snap_insn;
  logic [LEN_W-1:0]                   snap_len;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (insn_start) state_nxt = ST_REC;
      ST_REC: begin
        if (insn_start)     state_nxt = ST_REC;
        else if (insn_done) state_nxt = ST_RET;
      end
      ST_RET:  state_nxt = insn_start ? ST_REC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // insn_start redirects same-clk events to a fresh record; the old record still gets its tick.
  always_comb begin
    rec         = (state == ST_REC);
    evt_ok      = rec || insn_start;
    done_act    = rec && insn_done;
    base_idx    = insn_start ? '0 : idx_q;
    base_ovf    = insn_start ? 1'b0 : mc_ovf_q;
    base_len    = insn_start ? '0 : len_q;
    mc_take     = evt_ok && mcycle_start && !base_ovf && (base_idx < IDX_W'(MAX_MCYCLES));
    mc_drop     = evt_ok && mcycle_start && !mc_take;
    fb_take     = evt_ok && fetch_strobe && (base_len < LEN_W'(MAX_INSN_LEN));
    fb_old      = fb_take && !insn_start;
    old_tick_en = rec && !mc_ovf_q && (insn_start || !mcycle_start);
  end

`ifdef Z80FI_REC_ERR_EN
  logic [MAX_MCYCLES-1:0] sat_v;
`endif

  for (genvar g = 0; g < MAX_MCYCLES; g++) begin : g_slot
    assign load_v[g] = mc_take && (base_idx == IDX_W'(g));
    assign tick_v[g] = old_tick_en && (idx_q == IDX_W'(g + 1));

    z80fi_mcycle_slot #(
      .TCYC_W (TCYC_W)
    ) u_slot (
      .clk            (clk),
      .reset_n        (reset_n),
      .clear          (insn_start),
      .load           (load_v[g]),
      .tick           (tick_v[g]),
      .load_type      (mcycle_type),
      .snap_type_c    (snap_types[g*CYCLE_W +: CYCLE_W]),
      .snap_tcycles_c (snap_tcycles[g*TCYC_W +: TCYC_W])
`ifdef Z80FI_REC_ERR_EN
      ,
      .sat_c          (sat_v[g])
`endif
    );
  end

  always_comb begin
    snap_insn = '0;
    for (int k = 0; k < MAX_INSN_LEN; k++) begin
      snap_insn[8*k +: 8] = byte_q[k];
      if (fb_old && (len_q == LEN_W'(k))) snap_insn[8*k +: 8] = fetch_data;
    end
    snap_len = fb_old ? len_q + LEN_W'(1) : len_q;
  end

  // Working record: slot index, overflow latch and opcode byte buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q    <= '0;
      mc_ovf_q <= 1'b0;
      len_q    <= '0;
      for (int k = 0; k < MAX_INSN_LEN; k++) byte_q[k] <= '0;
    end else begin
      if (insn_start) begin
        idx_q    <= '0;
        mc_ovf_q <= 1'b0;
        len_q    <= '0;
      end
      if (mc_take) idx_q <= base_idx + IDX_W'(1);
      if (mc_drop) mc_ovf_q <= 1'b1;
      if (fb_take) len_q <= base_len + LEN_W'(1);
      for (int k = 0; k < MAX_INSN_LEN; k++) begin
        if (fb_take && (base_len == LEN_W'(k))) byte_q[k] <= fetch_data;
        else if (insn_start)                    byte_q[k] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      z80fi_valid       <= 1'b0;
      z80fi_insn        <= '0;
      z80fi_insn_len    <= '0;
      z80fi_mcycle_type <= {MAX_MCYCLES{CYCLE_W'(CYCLE_NONE)}};
      z80fi_tcycles     <= '0;
    end else begin
      z80fi_valid <= done_act;
      if (done_act) begin
        z80fi_insn        <= snap_insn;
        z80fi_insn_len    <= snap_len;
        z80fi_mcycle_type <= snap_types;
        z80fi_tcycles     <= snap_tcycles;
      end
    end
  end

`ifdef Z80FI_REC_ERR_EN
  logic err_q, err_snap, fb_drop;

  always_comb begin
    fb_drop  = evt_ok && fetch_strobe && !fb_take;
    err_snap = err_q || (|sat_v) || mc_drop || fb_drop;
  end

  // A fresh record starts flagged if its first clk carried no mcycle_start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q         <= 1'b0;
      z80fi_rec_err <= 1'b0;
    end else begin
      if (insn_start) err_q <= !mcycle_start;
      else if (rec)   err_q <= err_snap;
      z80fi_rec_err <= done_act ? err_snap : (rec && insn_start);
    end
  end
`endif

endmodule

// File: tb/tb_z80fi_insn_recorder.sv
// Scoreboard bench for z80fi_insn_recorder; optional checks follow Z80FI_REC_ERR_EN.
module tb_z80fi_insn_recorder;
  import z80fi_rec_pkg::*;

  localparam logic [2:0] M1  = CYCLE_M1;
  localparam logic [2:0] RD  = CYCLE_MEMRD;
  localparam logic [2:0] IOR = CYCLE_IORD;
  localparam logic [2:0] EXT = CYCLE_EXTENDED;
  localparam logic [2:0] NN  = CYCLE_NONE;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        insn_start, insn_done, mcycle_start, fetch_strobe;
  logic [2:0]  mcycle_type;
  logic [7:0]  fetch_data;
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [11:0] z80fi_mcycle_type;
  logic [15:0] z80fi_tcycles;
`ifdef Z80FI_REC_ERR_EN
  logic        z80fi_rec_err;
`endif

  always #5 clk = ~clk;

  z80fi_insn_recorder dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .insn_start        (insn_start),
    .insn_done         (insn_done),
    .mcycle_start      (mcycle_start),
    .mcycle_type       (mcycle_type),
    .fetch_strobe      (fetch_strobe),
    .fetch_data        (fetch_data),
    .z80fi_valid       (z80fi_valid),
    .z80fi_insn        (z80fi_insn),
    .z80fi_insn_len    (z80fi_insn_len),
    .z80fi_mcycle_type (z80fi_mcycle_type),
    .z80fi_tcycles     (z80fi_tcycles)
`ifdef Z80FI_REC_ERR_EN
    ,
    .z80fi_rec_err     (z80fi_rec_err)
`endif
  );

  typedef struct {
    logic [31:0] insn;
    logic [2:0]  len;
    logic [11:0] types;
    logic [15:0] tc;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  logic err_tok_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] insn, input logic [2:0] len,
                              input logic [2:0] t1, input logic [2:0] t2,
                              input logic [2:0] t3, input logic [2:0] t4,
                              input logic [3:0] c1, input logic [3:0] c2,
                              input logic [3:0] c3, input logic [3:0] c4,
                              input logic err);
    slot_t s [4];
    exp_t  r;
    s[0].mtype = t1; s[0].tcycles = c1;
    s[1].mtype = t2; s[1].tcycles = c2;
    s[2].mtype = t3; s[2].tcycles = c3;
    s[3].mtype = t4; s[3].tcycles = c4;
    r.insn  = insn;
    r.len   = len;
    r.types = {s[3].mtype, s[2].mtype, s[1].mtype, s[0].mtype};
    r.tc    = {s[3].tcycles, s[2].tcycles, s[1].tcycles, s[0].tcycles};
    r.err   = err;
    return r;
  endfunction

  task automatic cyc(input logic s, input logic d, input logic m, input logic [2:0] t,
                     input logic f, input logic [7:0] b);
    @(negedge clk);
    insn_start   = s;
    insn_done    = d;
    mcycle_start = m;
    mcycle_type  = t;
    fetch_strobe = f;
    fetch_data   = b;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, NN, 1'b0, 8'h00);
  endtask

  // One M-cycle of n clks; fetch lands on clk index fat (-1 for none).
  task automatic mcyc(input logic st, input logic d_first, input logic d_last, input logic [2:0] t,
                      input int n, input int fat, input logic [7:0] b);
    for (int i = 0; i < n; i++)
      cyc(st && (i == 0), (d_first && (i == 0)) || (d_last && (i == n - 1)), i == 0,
          (i == 0) ? t : NN, i == fat, b);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, 32'(z80fi_valid), 32'd0);
    chk({tag, "_insn"},  z80fi_insn, 32'd0);
    chk({tag, "_len"},   32'(z80fi_insn_len), 32'd0);
    chk({tag, "_types"}, 32'(z80fi_mcycle_type), 32'hFFF);
    chk({tag, "_tcyc"},  32'(z80fi_tcycles), 32'd0);
  endtask

  // Monitor: every valid pulse pops and checks one expected record.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (z80fi_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got valid=1, expected no record");
        end else begin
          e = exp_q.pop_front();
          chk("rec_insn",  z80fi_insn, e.insn);
          chk("rec_len",   32'(z80fi_insn_len), 32'(e.len));
          chk("rec_types", 32'(z80fi_mcycle_type), 32'(e.types));
          chk("rec_tcyc",  32'(z80fi_tcycles), 32'(e.tc));
`ifdef Z80FI_REC_ERR_EN
          chk("rec_err",   32'(z80fi_rec_err), 32'(e.err));
`endif
        end
      end
`ifdef Z80FI_REC_ERR_EN
      if (z80fi_rec_err === 1'b1 && z80fi_valid !== 1'b1) begin
        if (err_tok_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_err_pulse: got rec_err=1, expected 0");
        end else begin
          chk("proto_err_pulse", 32'(z80fi_rec_err), 32'(err_tok_q.pop_front()));
        end
      end
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    insn_start = 1'b0; insn_done = 1'b0; mcycle_start = 1'b0;
    mcycle_type = NN; fetch_strobe = 1'b0; fetch_data = 8'h00;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    reset_n = 1'b1;

    // LD A,I
    exp_q.push_back(mk(32'h57ED, 3'd2, M1, M1, EXT, NN, 4'd4, 4'd4, 4'd1, 4'd0, 1'b0));
    mcyc(1'b1, 1'b0, 1'b0, M1, 4, 1, 8'hED);
    mcyc(1'b0, 1'b0, 1'b0, M1, 4, 1, 8'h57);
    mcyc(1'b0, 1'b0, 1'b1, EXT, 1, -1, 8'h00);
    idle(2);

    // NOP then LD A,I, done and start sharing one clk
    exp_q.push_back(mk(32'h00, 3'd1, M1, NN, NN, NN, 4'd4, 4'd0, 4'd0, 4'd0, 1'b0));
    exp_q.push_back(mk(32'h57ED, 3'd2, M1, M1, EXT, NN, 4'd4, 4'd4, 4'd1, 4'd0, 1'b0));
    mcyc(1'b1, 1'b0, 1'b0, M1, 3, 1, 8'h00);
    mcyc(1'b1, 1'b1, 1'b0, M1, 4, 1, 8'hED);
    mcyc(1'b0, 1'b0, 1'b0, M1, 4, 1, 8'h57);
    mcyc(1'b0, 1'b0, 1'b1, EXT, 1, -1, 8'h00);
    idle(2);

    // Stray events in IDLE, then six 3T M-cycles
    cyc(1'b0, 1'b1, 1'b1, IOR, 1'b1, 8'hFF);
    exp_q.push_back(mk(32'h11, 3'd1, M1, RD, RD, RD, 4'd3, 4'd3, 4'd3, 4'd3, 1'b1));
    mcyc(1'b1, 1'b0, 1'b0, M1, 3, 1, 8'h11);
    for (int i = 0; i < 5; i++) mcyc(1'b0, 1'b0, i == 4, RD, 3, -1, 8'h00);
    idle(2);

    // Long M1 saturates its T-count
    exp_q.push_back(mk(32'h76, 3'd1, M1, NN, NN, NN, 4'd15, 4'd0, 4'd0, 4'd0, 1'b1));
    mcyc(1'b1, 1'b0, 1'b1, M1, 24, 1, 8'h76);
    idle(2);

    // Reset mid-record after two fetches
    mcyc(1'b1, 1'b0, 1'b0, M1, 4, 1, 8'hED);
    cyc(1'b0, 1'b0, 1'b1, M1, 1'b1, 8'h57);
    @(negedge clk);
    reset_n = 1'b0;
    insn_start = 1'b0; insn_done = 1'b0; mcycle_start = 1'b0;
    mcycle_type = NN; fetch_strobe = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_cleared("midrec_reset");
    exp_q.push_back(mk(32'h3C, 3'd1, M1, NN, NN, NN, 4'd4, 4'd0, 4'd0, 4'd0, 1'b0));
    mcyc(1'b1, 1'b0, 1'b1, M1, 4, 1, 8'h3C);
    idle(2);

    // Restart without done; final fetch on the done clk is kept
    exp_q.push_back(mk(32'h122F, 3'd2, M1, RD, NN, NN, 4'd4, 4'd3, 4'd0, 4'd0, 1'b0));
`ifdef Z80FI_REC_ERR_EN
    err_tok_q.push_back(1'b1);
`endif
    mcyc(1'b1, 1'b0, 1'b0, M1, 4, 1, 8'hDD);
    mcyc(1'b1, 1'b0, 1'b0, M1, 4, 1, 8'h2F);
    mcyc(1'b0, 1'b0, 1'b1, RD, 3, 2, 8'h12);
    idle(2);

    // Fifth opcode byte is dropped
    exp_q.push_back(mk(32'h0605CBDD, 3'd4, M1, M1, RD, RD, 4'd4, 4'd4, 4'd3, 4'd3, 1'b1));
    mcyc(1'b1, 1'b0, 1'b0, M1, 4, 1, 8'hDD);
    mcyc(1'b0, 1'b0, 1'b0, M1, 4, 1, 8'hCB);
    mcyc(1'b0, 1'b0, 1'b0, RD, 3, 1, 8'h05);
    mcyc(1'b0, 1'b0, 1'b0, RD, 2, 1, 8'h06);
    cyc(1'b0, 1'b1, 1'b0, NN, 1'b1, 8'h77);
    idle(4);

    chk("records_pending", 32'(exp_q.size()), 32'd0);
    chk("err_pulses_pending", 32'(err_tok_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
